// File: rtl/pipelined_adder.sv
// W-bit add/sub whose carry chain is cut into STAGES registered chunks, with valid/ready back-pressure.
// Optional macro PIPELINED_ADDER_SAT_EN: saturate S to signed max/min on overflow.
module pipelined_adder #(
    parameter int W      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin,
    input  logic         sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] S,
    output logic         cout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int CW = W / STAGES;
    localparam int L  = STAGES - 1;

    // Per-stage registers: operands travel whole, chunk k of s_q is final after stage k.
    logic [W-1:0]        a_q [STAGES];
    logic [W-1:0]        b_q [STAGES];
    logic [W-1:0]        s_q [STAGES];
    logic                c_q [STAGES];
    logic [STAGES-1:0]   vld_pipe_q;
    logic                ovf_q;

    logic [W-1:0]        a_stg [STAGES];
    logic [W-1:0]        b_stg [STAGES];
    logic [W-1:0]        s_stg [STAGES];
    logic                c_stg [STAGES];
    logic                v_stg [STAGES];
    logic [W-1:0]        s_d   [STAGES];
    logic                c_d   [STAGES];

    logic                advance;
    logic                ovf_d;
    logic [W-1:0]        s_fin;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [CW:0] chunk;
        if (k == 0) begin : g_head
            assign a_stg[0] = A;
            assign b_stg[0] = sub ? ~B : B;
            assign c_stg[0] = sub ? ~cin : cin;
            assign s_stg[0] = '0;
            assign v_stg[0] = in_valid;
        end else begin : g_body
            assign a_stg[k] = a_q[k-1];
            assign b_stg[k] = b_q[k-1];
            assign c_stg[k] = c_q[k-1];
            assign s_stg[k] = s_q[k-1];
            assign v_stg[k] = vld_pipe_q[k-1];
        end
        assign chunk  = {1'b0, a_stg[k][k*CW +: CW]} + {1'b0, b_stg[k][k*CW +: CW]}
                      + (CW+1)'(c_stg[k]);
        assign s_d[k] = s_stg[k] | (W'(chunk[CW-1:0]) << (k*CW));
        assign c_d[k] = chunk[CW];
    end

    assign ovf_d = (a_stg[L][W-1] == b_stg[L][W-1]) && (s_d[L][W-1] != a_stg[L][W-1]);

`ifdef PIPELINED_ADDER_SAT_EN
    assign s_fin = !ovf_d ? s_d[L]
                 : (a_stg[L][W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
`else
    assign s_fin = s_d[L];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            ovf_q      <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_pipe_q[k] <= v_stg[k];
                a_q[k]        <= a_stg[k];
                b_q[k]        <= b_stg[k];
            end
            for (int k = 0; k < L; k++) begin
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            // Output registers keep the last result across bubbles.
            if (v_stg[L]) begin
                s_q[L] <= s_fin;
                c_q[L] <= c_d[L];
                ovf_q  <= ovf_d;
            end
        end
    end

    assign S         = s_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_q;
    assign out_valid = vld_pipe_q[L];

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined successor of the combinational W-bit adder. Splits the W-bit carry chain into STAGES registered chunks so wide adds close timing at high clock rates. Adds add/subtract mode, signed-overflow flag and a valid/ready handshake with back-pressure. Used wherever a datapath needs a registered wide add/sub with flow control.

Parameters:
W, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline stages and carry-chain chunks; 1..W; chunk width CW = W/STAGES.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset; synchronous, active-high.
A  input  W  operand A.
B  input  W  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0: S = A + B + cin; 1: S = A - B - cin.
in_valid  input  1  operand set valid.
in_ready  output  1  block accepts operands this cycle.
S  output  W  result.
cout  output  1  raw carry out of MSB of the internal add.
ovf  output  1  two's-complement signed overflow.
out_valid  output  1  S/cout/ovf valid.
out_ready  input  1  consumer accepts result this cycle.

Behaviour:
- Effective operand: Beff = sub ? ~B : B; carry0 = sub ? ~cin : cin. Internal add always A + Beff + carry0.
- Stage k (0..STAGES-1) computes chunk k bits [k*CW +: CW] from chunk k of A/Beff and the carry registered by stage k-1 (stage 0 uses carry0). Unprocessed higher chunks travel in skew registers; finished lower chunks travel in alignment registers.
- Each stage has a valid bit. Global advance = !(out_valid && !out_ready). in_ready = advance. On advance all stage registers shift one step; stage 0 captures inputs, its valid = in_valid. On no-advance every register holds.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: exactly STAGES cycles from accepted input to out_valid when no stall. Throughput 1 op/cycle with out_ready=1.
- cout = carry out of final chunk. With sub=1 cout=1 means no borrow.
- ovf = (A[W-1] == Beff[W-1]) && (S[W-1] != A[W-1]), using A/Beff MSBs carried down the pipe.
- Bubbles (in_valid=0) propagate as valid=0 stages; output data registers hold last value when out_valid=0.
- Order preserved; no result dropped or duplicated under any out_ready pattern.
- Reset (any cycle, including mid-operation): all stage valids=0, out_valid=0, S=0, cout=0, ovf=0; in-flight ops discarded; in_ready=1 the cycle after reset deasserts. While rst=1 in_ready=0.
- STAGES=1: single registered adder, latency 1.

Optional Feature:
Macro PIPELINED_ADDER_SAT_EN. Defined: when ovf=1, S saturates to signed max 0x7F..F (A[W-1]=0) or signed min 0x80..0 (A[W-1]=1); ovf and cout still report raw condition. Not defined: S is wrapped modulo 2^W; no saturation logic present.

Test Plan:
(W=32, STAGES=4 unless noted.)
1. rst=1 two cycles, release -> out_valid=0, S=0, cout=0, ovf=0, in_ready=1 next cycle.
2. A=0xFFFFFFFF, B=1, cin=0, sub=0, out_ready=1 -> 4 cycles later S=0x00000000, cout=1, ovf=0 (carry crosses all chunks).
3. Eight back-to-back adds A=i, B=0x10*i, cin=i&1, out_ready=1 -> eight results on consecutive cycles, in order, correct values; then bubble -> out_valid=0.
4. Stream with out_ready=0 for 3 cycles while out_valid=1 -> S held constant, in_ready=0, no accepted input; after release all results emerge in order, none lost.
5. sub=1: A=5, B=7, cin=0 -> S=0xFFFFFFFE, cout=0, ovf=0; A=0x80000000, B=1, cin=0 -> S=0x7FFFFFFF, ovf=1; with PIPELINED_ADDER_SAT_EN: S=0x80000000.
6. Assert rst for one cycle while 3 ops in flight -> no out_valid for those ops; next accepted op A=2, B=3 -> S=5 after 4 cycles. Repeat test 2 with STAGES=1 -> latency 1.
